mo_tree_adder_pipe: RTL and testbench

//   Pipelined multi-operand binary-tree adder: reduces N_OPS unsigned/signed operands of WIDTH bits
//   to one full-precision sum, one tree level per clock stage. Successor to the single-pair ripple

---
 rtl/mo_tree_adder_pipe.sv | 84 ++++++++
 tb/tb_mo_tree_adder_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mo_tree_adder_pipe.sv
// Pipelined multi-operand binary-tree adder: one tree level per register stage,
// global-stall valid/ready flow control, exact full-precision sum.
module mo_tree_adder_pipe #(
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned N_OPS  = 8,
  parameter int unsigned SIGNED = 0,
  localparam int unsigned LEVELS = $clog2(N_OPS),
  localparam int unsigned OUT_W  = WIDTH + LEVELS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] in_ops,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sum,
  output logic                   busy
);

  // Extension bit source: sign bit when signed, zero otherwise.
  localparam logic SX = (SIGNED != 0);

  // Number of partial sums held at tree level l (level 0 = raw operands).
  function automatic int unsigned stage_cnt(input int unsigned l);
    return (N_OPS + (32'd1 << l) - 32'd1) >> l;
  endfunction

  logic [LEVELS-1:0] stage_v;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned PW = WIDTH + l - 1;
    localparam int unsigned SW = WIDTH + l;
    localparam int unsigned PC = stage_cnt(l - 1);
    localparam int unsigned SC = stage_cnt(l);

    logic [PC*PW-1:0] prev;
    logic             prev_v;
    logic [SC*SW-1:0] sum_c;
    logic [SC*SW-1:0] data;
    logic             v;

    // Previous level: raw operands for the first stage, else the prior register stage.
    if (l == 1) begin : g_src
      assign prev   = in_ops;
      assign prev_v = in_valid;
    end else begin : g_src
      assign prev   = g_lvl[l-1].data;
      assign prev_v = g_lvl[l-1].v;
    end

    // Pairwise add of entries 2j,2j+1; an unpaired last entry passes through extended.
    always_comb begin
      sum_c = '0;
      for (int unsigned j = 0; j < PC / 2; j++) begin
        sum_c[j*SW +: SW] = {SX & prev[2*j*PW + PW - 1],     prev[2*j*PW +: PW]}
                          + {SX & prev[(2*j+1)*PW + PW - 1], prev[(2*j+1)*PW +: PW]};
      end
      if (PC % 2 == 1) begin
        sum_c[(SC-1)*SW +: SW] = {SX & prev[PC*PW - 1], prev[(PC-1)*PW +: PW]};
      end
    end

    // Stage register: shifts on advance, holds on global stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data <= '0;
        v    <= 1'b0;
      end else if (in_ready) begin
        data <= sum_c;
        v    <= prev_v;
      end
    end

    assign stage_v[l-1] = v;
  end

  // Advance whenever the output register is empty or being drained.
  assign in_ready  = !out_valid || out_ready;
  assign out_valid = g_lvl[LEVELS].v;
  assign out_sum   = g_lvl[LEVELS].data;
  assign busy      = |stage_v;

endmodule

// File: tb/tb_mo_tree_adder_pipe.sv
// Scoreboard bench for mo_tree_adder_pipe: three lockstep instances
// (unsigned 8x19, signed 8x19, unsigned 5x8) sharing handshake inputs.
module tb_mo_tree_adder_pipe;
  localparam int unsigned W   = 19;
  localparam int unsigned N   = 8;
  localparam int unsigned OW  = 22;
  localparam int unsigned MW  = N * W;
  localparam int unsigned W5  = 8;
  localparam int unsigned N5  = 5;
  localparam int unsigned OW5 = 11;
  localparam int unsigned M5  = N5 * W5;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [MW-1:0] ops_m = '0;
  logic [MW-1:0] ops_s = '0;
  logic [M5-1:0] ops_5 = '0;
  logic rdy_m, rdy_s, rdy_5, ov_m, ov_s, ov_5, busy_m, busy_s, busy_5;
  logic [OW-1:0]  sum_m, sum_s;
  logic [OW5-1:0] sum_5;

  typedef struct {
    logic [OW-1:0]  em;
    logic [OW-1:0]  es;
    logic [OW5-1:0] e5;
    int             acc;
    bit             lat;
    bit             seen;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  mo_tree_adder_pipe #(.WIDTH(W), .N_OPS(N), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m), .in_ops(ops_m),
    .out_valid(ov_m), .out_ready(out_ready), .out_sum(sum_m), .busy(busy_m));

  mo_tree_adder_pipe #(.WIDTH(W), .N_OPS(N), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .in_ops(ops_s),
    .out_valid(ov_s), .out_ready(out_ready), .out_sum(sum_s), .busy(busy_s));

  mo_tree_adder_pipe #(.WIDTH(W5), .N_OPS(N5), .SIGNED(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_5), .in_ops(ops_5),
    .out_valid(ov_5), .out_ready(out_ready), .out_sum(sum_5), .busy(busy_5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Present one vector to all instances and queue expected sums once accepted.
  task automatic issue(input logic [MW-1:0] om, input logic [OW-1:0] em,
                       input logic [MW-1:0] os, input logic [OW-1:0] es,
                       input logic [M5-1:0] o5, input logic [OW5-1:0] e5, input bit lat);
    bit   acc = 1'b0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    ops_m = om;
    ops_s = os;
    ops_5 = o5;
    for (int n = 0; n < 64 && !acc; n++) begin
      #1;
      if (rdy_m) begin
        e.em = em; e.es = es; e.e5 = e5;
        e.acc = cyc; e.lat = lat; e.seen = 1'b0;
        sb.push_back(e);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) fail("accept_timeout");
  endtask

  // Bubble cycles with junk operand data.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      ops_m = MW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      ops_s = MW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      ops_5 = M5'({$urandom(), $urandom()});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
    @(negedge clk);
    #3;
    check("busy_idle_m", 64'(busy_m), 64'(0));
    check("busy_idle_5", 64'(busy_5), 64'(0));
  endtask

  // Monitor: compares presented outputs against the queue head, pops on handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check("in_ready", 64'(rdy_m), 64'(!ov_m || out_ready));
        if (ov_m || ov_s || ov_5) begin
          if (sb.size() == 0) begin
            fail("spurious_out_valid");
          end else begin
            e = sb[0];
            check("valid_m", 64'(ov_m), 64'(1));
            check("valid_s", 64'(ov_s), 64'(1));
            check("valid_5", 64'(ov_5), 64'(1));
            check("sum_m", 64'(sum_m), 64'(e.em));
            check("sum_s", 64'(sum_s), 64'(e.es));
            check("sum_5", 64'(sum_5), 64'(e.e5));
            if (e.lat && !e.seen) check("latency", 64'(cyc), 64'(e.acc + LAT));
            sb[0].seen = 1'b1;
            if (ov_m && out_ready) void'(sb.pop_front());
          end
        end else if (sb.size() != 0 && sb[0].lat && !sb[0].seen && cyc > sb[0].acc + LAT) begin
          fail("latency_late");
          sb[0].seen = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(ov_m), 64'(0));
    check("rst_out_sum", 64'(sum_m), 64'(0));
    check("rst_busy", 64'(busy_m), 64'(0));
    check("rst_in_ready", 64'(rdy_m), 64'(1));
    check("rst_out_valid_5", 64'(ov_5), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // All-max unsigned, signed -1s / mixed signs, 5-operand width-8 cases
    issue({N{19'h7FFFF}}, 22'h3FFFF8, '0, '0, '0, '0, 1'b1);
    issue('0, '0, {N{19'h7FFFF}}, 22'h3FFFF8, '0, '0, 1'b1);
    issue('0, '0, {19'h0, 19'h0, 19'h0, 19'h0, 19'h40000, 19'h3FFFF, 19'h7FFFD, 19'h00005},
          22'h000001, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 11'd15, 1'b1);
    issue({N{19'h40000}}, 22'h200000, {N{19'h40000}}, 22'h200000, {N5{8'hFF}}, 11'h4FB, 1'b1);
    idle(1);
    drain();

    // Back-to-back six vectors with a four-cycle downstream stall
    fork
      for (int k = 1; k <= 6; k++) begin
        issue(MW'({19'(4*k), 19'(3*k), 19'(2*k), 19'(k)}), OW'(10*k), '0, '0,
              M5'({8'(5*k), 8'(4*k), 8'(3*k), 8'(2*k), 8'(k)}), OW5'(15*k), 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(1);
    drain();

    // Bubbles: valid 1,0,1,0
    issue({N{19'h00001}}, 22'h000008, '0, '0, '0, '0, 1'b1);
    idle(1);
    issue(MW'(19'h12345), 22'h012345, '0, '0, '0, '0, 1'b1);
    idle(1);
    drain();

    // Reset with three vectors in flight
    issue({N{19'h00002}}, 22'h000010, '0, '0, '0, '0, 1'b0);
    issue({N{19'h00004}}, 22'h000020, '0, '0, '0, '0, 1'b0);
    issue({N{19'h00006}}, 22'h000030, '0, '0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(ov_m), 64'(1));
    check("pre_reset_sum", 64'(sum_m), 64'(22'h000010));
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ov_m), 64'(0));
    check("mid_rst_busy", 64'(busy_m), 64'(0));
    check("mid_rst_sum", 64'(sum_m), 64'(0));
    check("mid_rst_in_ready", 64'(rdy_m), 64'(1));
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue({N{19'h00003}}, 22'h000018, '0, '0, '0, '0, 1'b1);
    idle(1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
